// File: rtl/lsu_mem_stage.sv
// Load/store memory stage: one data-memory transaction per start over a req/ready
// handshake, with byte-lane steering for stores and sign/zero extension for loads.
module lsu_mem_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        done,
    output logic [1:0]  fault,
    output logic [31:0] load_data
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [1:0] F_OK      = 2'b00;
    localparam logic [1:0] F_MISAL   = 2'b01;
    localparam logic [1:0] F_TIMEOUT = 2'b10;
    localparam logic [1:0] F_ILLEGAL = 2'b11;

    logic [1:0]  r_state;
    logic [7:0]  r_cnt;
    logic        r_store;
    logic [2:0]  r_f3;
    logic [1:0]  r_off;
    logic [1:0]  r_fault_pend;

    logic        w_illegal;
    logic        w_misal;
    logic [31:0] w_wdata;
    logic [3:0]  w_wstrb;
    logic [31:0] w_shift;
    logic [31:0] w_load;
    logic [7:0]  w_cnt_nxt;
    logic        w_timeout;

    always_comb begin
        if (is_store)
            w_illegal = (funct3 > 3'b010);
        else
            w_illegal = !(funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        w_misal = ((funct3[1:0] == 2'b01) && addr[0]) ||
                  ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    end

    always_comb begin
        w_wdata = store_data;
        w_wstrb = 4'b0000;
        case (funct3[1:0])
            2'b00: begin
                w_wdata = {4{store_data[7:0]}};
                w_wstrb = 4'b0001 << addr[1:0];
            end
            2'b01: begin
                w_wdata = {2{store_data[15:0]}};
                w_wstrb = 4'b0011 << addr[1:0];
            end
            default: begin
                w_wdata = store_data;
                w_wstrb = 4'b1111;
            end
        endcase
        if (!is_store)
            w_wstrb = 4'b0000;
    end

    // Extraction uses the offset latched at start, not the live address.
    always_comb begin
        w_shift = mem_rdata >> {r_off, 3'b000};
        case (r_f3)
            3'b000:  w_load = {{24{w_shift[7]}}, w_shift[7:0]};
            3'b100:  w_load = {24'd0, w_shift[7:0]};
            3'b001:  w_load = {{16{w_shift[15]}}, w_shift[15:0]};
            3'b101:  w_load = {16'd0, w_shift[15:0]};
            default: w_load = mem_rdata;
        endcase
    end

    assign w_cnt_nxt = r_cnt + 8'd1;
    assign w_timeout = (w_cnt_nxt == 8'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_store      <= 1'b0;
            r_f3         <= '0;
            r_off        <= '0;
            r_fault_pend <= F_OK;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_wstrb    <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            fault        <= F_OK;
            load_data    <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_store <= is_store;
                        r_f3    <= funct3;
                        r_off   <= addr[1:0];
                        busy    <= 1'b1;
                        r_cnt   <= '0;
                        if (w_illegal) begin
                            r_fault_pend <= F_ILLEGAL;
                            r_state      <= S_DONE;
                        end else if (w_misal) begin
                            r_fault_pend <= F_MISAL;
                            r_state      <= S_DONE;
                        end else begin
                            mem_req   <= 1'b1;
                            mem_we    <= is_store;
                            mem_addr  <= {addr[31:2], 2'b00};
                            mem_wdata <= w_wdata;
                            mem_wstrb <= w_wstrb;
                            r_state   <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    // Ready is checked first so it wins on the timeout edge.
                    if (mem_ready) begin
                        mem_req      <= 1'b0;
                        mem_we       <= 1'b0;
                        r_fault_pend <= F_OK;
                        r_state      <= S_DONE;
                        if (!r_store)
                            load_data <= w_load;
                    end else if (w_timeout) begin
                        mem_req      <= 1'b0;
                        mem_we       <= 1'b0;
                        r_fault_pend <= F_TIMEOUT;
                        r_state      <= S_DONE;
                    end else begin
                        r_cnt <= w_cnt_nxt;
                    end
                end
                S_DONE: begin
                    done    <= 1'b1;
                    fault   <= r_fault_pend;
                    busy    <= 1'b0;
                    r_cnt   <= '0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Bench for lsu_mem_stage (TIMEOUT_CYCLES=4): vector table driven back-to-back,
// completions checked against a queue of expected results, plus busy/reset sequences.
module tb_lsu_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        busy;
    logic        done;
    logic [1:0]  fault;
    logic [31:0] load_data;

    lsu_mem_stage #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .is_store(is_store),
        .funct3(funct3), .addr(addr), .store_data(store_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .busy(busy), .done(done), .fault(fault),
        .load_data(load_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] rdata;
        int          wait_c;
        logic [1:0]  fault;
        logic [31:0] load;
        logic [31:0] maddr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          lat;
        int          reqc;
    } vec_t;

    typedef struct {
        logic [1:0]  fault;
        logic [31:0] load;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && done === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no completion at %0t", $time);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("fault", 32'(fault), 32'(e.fault));
                chk("load_data", load_data, e.load);
            end
        end
    end

    // Called at a negedge; returns at the negedge on which done is seen.
    task automatic run(input vec_t v, input bit repulse);
        int k;
        int reqc;
        bit seen;
        start      = 1'b1;
        is_store   = v.st;
        funct3     = v.f3;
        addr       = v.addr;
        store_data = v.sdata;
        mem_rdata  = v.rdata;
        mem_ready  = 1'b0;
        sb_q.push_back('{fault: v.fault, load: v.load});
        @(negedge clk);
        start = 1'b0;
        k = 0; reqc = 0; seen = 1'b0;
        while (!seen && k < 20) begin
            if (k == 0) begin
                chk("busy", 32'(busy), 32'd1);
                if (v.reqc > 0) begin
                    chk("mem_we", 32'(mem_we), 32'(v.st));
                    chk("mem_wdata", mem_wdata, v.wdata);
                    chk("mem_wstrb", 32'(mem_wstrb), 32'(v.wstrb));
                end else begin
                    chk("mem_req_fault", 32'(mem_req), 32'd0);
                end
            end
            if (mem_req) begin
                reqc++;
                chk("mem_addr", mem_addr, v.maddr);
            end
            start = repulse && (k == 0);
            if (done) begin
                seen = 1'b1;
            end else begin
                mem_ready = (k == v.wait_c);
                @(negedge clk);
                k++;
            end
        end
        mem_ready = 1'b0;
        start     = 1'b0;
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL done_bound: got no done within 20 cycles expected latency %0d", v.lat);
            void'(sb_q.pop_back());
        end else begin
            chk("latency", 32'(k), 32'(v.lat));
            chk("req_cycles", 32'(reqc), 32'(v.reqc));
        end
    endtask

    vec_t tbl[$];
    vec_t v;

    initial begin
        // st f3 addr sdata rdata wait fault load maddr wdata wstrb lat reqc
        tbl.push_back('{0, 3'b000, 32'h103, 32'h0, 32'h80AABBCC, 0, 2'b00, 32'hFFFFFF80, 32'h100, 32'h0, 4'b0000, 2, 1});
        tbl.push_back('{0, 3'b100, 32'h103, 32'h0, 32'h80AABBCC, 0, 2'b00, 32'h00000080, 32'h100, 32'h0, 4'b0000, 2, 1});
        tbl.push_back('{1, 3'b001, 32'h202, 32'h1234ABCD, 32'h0, 0, 2'b00, 32'h00000080, 32'h200, 32'hABCDABCD, 4'b1100, 2, 1});
        tbl.push_back('{0, 3'b010, 32'h101, 32'h0, 32'h0, 99, 2'b01, 32'h00000080, 32'h0, 32'h0, 4'b0000, 1, 0});
        tbl.push_back('{1, 3'b011, 32'h200, 32'h0, 32'h0, 99, 2'b11, 32'h00000080, 32'h0, 32'h0, 4'b0000, 1, 0});
        tbl.push_back('{0, 3'b001, 32'h202, 32'h0, 32'h80011234, 2, 2'b00, 32'hFFFF8001, 32'h200, 32'h0, 4'b0000, 4, 3});
        tbl.push_back('{0, 3'b101, 32'h100, 32'h0, 32'h1234F00D, 1, 2'b00, 32'h0000F00D, 32'h100, 32'h0, 4'b0000, 3, 2});
        tbl.push_back('{1, 3'b000, 32'h301, 32'h000000A5, 32'h0, 0, 2'b00, 32'h0000F00D, 32'h300, 32'hA5A5A5A5, 4'b0010, 2, 1});
        tbl.push_back('{1, 3'b010, 32'h404, 32'hDEADBEEF, 32'h0, 0, 2'b00, 32'h0000F00D, 32'h404, 32'hDEADBEEF, 4'b1111, 2, 1});
        tbl.push_back('{0, 3'b010, 32'h400, 32'h0, 32'hCAFEF00D, 0, 2'b00, 32'hCAFEF00D, 32'h400, 32'h0, 4'b0000, 2, 1});
        tbl.push_back('{0, 3'b010, 32'h004, 32'h0, 32'h99999999, 99, 2'b10, 32'hCAFEF00D, 32'h004, 32'h0, 4'b0000, 5, 4});
        tbl.push_back('{0, 3'b010, 32'h008, 32'h0, 32'h11223344, 3, 2'b00, 32'h11223344, 32'h008, 32'h0, 4'b0000, 5, 4});
        tbl.push_back('{0, 3'b011, 32'h008, 32'h0, 32'h0, 99, 2'b11, 32'h11223344, 32'h0, 32'h0, 4'b0000, 1, 0});
        tbl.push_back('{0, 3'b110, 32'h008, 32'h0, 32'h0, 99, 2'b11, 32'h11223344, 32'h0, 32'h0, 4'b0000, 1, 0});
        tbl.push_back('{0, 3'b001, 32'h103, 32'h0, 32'h0, 99, 2'b01, 32'h11223344, 32'h0, 32'h0, 4'b0000, 1, 0});
        tbl.push_back('{1, 3'b100, 32'h003, 32'h0, 32'h0, 99, 2'b11, 32'h11223344, 32'h0, 32'h0, 4'b0000, 1, 0});
        tbl.push_back('{0, 3'b000, 32'h101, 32'h0, 32'h00007F00, 0, 2'b00, 32'h0000007F, 32'h100, 32'h0, 4'b0000, 2, 1});

        rst_n = 1'b0; start = 1'b0; is_store = 1'b0; funct3 = '0; addr = '0;
        store_data = '0; mem_ready = 1'b0; mem_rdata = '0;
        repeat (2) @(negedge clk);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
        chk("rst_load_data", load_data, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (tbl[i]) run(tbl[i], 1'b0);
        repeat (2) @(negedge clk);

        // start pulsed again while in REQ must not launch a second transaction
        v = '{0, 3'b010, 32'h040, 32'h0, 32'h55667788, 2, 2'b00, 32'h55667788, 32'h040, 32'h0, 4'b0000, 4, 3};
        run(v, 1'b1);
        repeat (4) @(negedge clk);
        chk("busy_after_repulse", 32'(busy), 32'd0);
        chk("queue_after_repulse", 32'(sb_q.size()), 32'd0);

        // asynchronous reset in the middle of REQ
        start = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h10; mem_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        chk("midrst_req_before", 32'(mem_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_mem_req", 32'(mem_req), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_load_data", load_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        v = '{0, 3'b010, 32'h020, 32'h0, 32'h0BADF00D, 0, 2'b00, 32'h0BADF00D, 32'h020, 32'h0, 4'b0000, 2, 1};
        run(v, 1'b0);
        repeat (3) @(negedge clk);
        chk("queue_empty", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got simulation still running expected completion");
        $fatal(1, "bench time limit");
    end

endmodule

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
- Load/store unit sitting directly downstream of the ALU.
- Takes the ALU result as the effective address and, for stores, the rs2 value as write data.
- Runs one data-memory transaction over a req/ready handshake, with byte-lane steering and sign/zero extension.
- Returns load data for writeback. The core stalls on `busy` while a transaction is in flight.

Parameters:
- TIMEOUT_CYCLES, default 255: number of wait cycles in REQ without `mem_ready` before the transaction is aborted with a timeout fault. Legal range 1..255.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a transaction; sampled only in IDLE.
- is_store  input  1  1 = store, 0 = load.
- funct3  input  3  RISC-V size/sign field.
- addr  input  32  effective address (ALU `alu_out`).
- store_data  input  32  rs2 value for stores.
- mem_req  output  1  bus request; held until accepted or timed out.
- mem_we  output  1  write enable, qualified by `mem_req`.
- mem_addr  output  32  word-aligned address, {addr[31:2],2'b00}.
- mem_wdata  output  32  lane-replicated store data.
- mem_wstrb  output  4  byte strobes; 0000 on loads.
- mem_ready  input  1  bus accepts/completes the transaction on the current edge.
- mem_rdata  input  32  read word, valid when `mem_ready`=1.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle completion pulse.
- fault  output  2  00 ok, 01 misaligned, 10 timeout, 11 illegal funct3; valid with `done`.
- load_data  output  32  extended load result; holds its value until the next successful load.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; `mem_req`, `mem_we`, `busy`, `done` = 0; `fault`=00; `mem_addr`, `mem_wdata`, `load_data` = 0; `mem_wstrb`=0000; wait counter = 0.
- All outputs are registered.
- Reset asserted mid-transaction drops `mem_req` immediately. No `done` is produced. `load_data` is cleared.
- States: IDLE, REQ, DONE.
- IDLE transitions on `start`=1. On that edge, `is_store`, `funct3`, `addr` and `store_data` are latched.
  - funct3 illegal → DONE with fault=11. Loads accept 000/001/010/100/101; stores accept 000/001/010.
  - Misaligned → DONE with fault=01. Halfword is misaligned when addr[0]=1; word when addr[1:0]≠00.
  - Otherwise → REQ. `mem_req`=1, `mem_we`=`is_store`, and `mem_addr`, `mem_wdata`, `mem_wstrb` are driven.
  - Illegal takes priority over misaligned. No bus activity occurs on any fault.
- REQ, on each edge:
  - `mem_ready`=1 → DONE with fault=00. For loads, `load_data` is updated from `mem_rdata` on that edge.
  - `mem_ready`=0 → wait counter increments. When the counter reaches TIMEOUT_CYCLES → DONE with fault=10, `mem_req` drops, `load_data` is unchanged.
  - `mem_ready` is sampled before the timeout compare, so a ready arriving on the timeout edge wins.
  - Address, data and strobes are stable throughout REQ.
- DONE: `done`=1 for exactly one cycle, `mem_req`=0, counter cleared, then IDLE.
- `start` in REQ or DONE is ignored, not queued.
- Latency, counted from the edge that samples `start`:
  - zero-wait memory: `done` high 2 cycles after;
  - each bus wait cycle adds 1;
  - fault cases: `done` 1 cycle after.
- Store lane steering (off = addr[1:0]):
  - SB: wdata = byte replicated ×4, wstrb = 0001<<off.
  - SH: wdata = halfword replicated ×2, wstrb = 0011<<off.
  - SW: wdata = store_data, wstrb = 1111.
- Load extraction uses the latched off:
  - LB/LBU: byte = rdata[8*off+7 : 8*off], sign-/zero-extended to 32 bits.
  - LH/LHU: half = rdata[8*off+15 : 8*off], sign-/zero-extended.
  - LW: full word.
- Stores never modify `load_data`.

Test Plan:
- Load bytes: LB at addr 0x0000_0103, `mem_rdata`=0x80AA_BBCC, `mem_ready` same cycle as `mem_req` → `mem_addr`=0x100, `load_data`=0xFFFF_FF80, fault=00, `done` 2 cycles after start. Repeat as LBU → `load_data`=0x0000_0080.
- Store halfword: SH at addr 0x202, `store_data`=0x1234_ABCD → `mem_we`=1, `mem_wdata`=0xABCD_ABCD, `mem_wstrb`=1100, `mem_addr`=0x200; `load_data` unchanged.
- Faults: LW at addr 0x101 → `mem_req` never asserts, `done` 1 cycle after start, fault=01. Store with funct3=011 at aligned address → fault=11.
- Timeout (TIMEOUT_CYCLES=4): LW with `mem_ready` held 0 → `mem_req` high 4 cycles then drops, `done` with fault=10, `load_data` retains prior value. Second run with `mem_ready` asserted on the 4th wait edge → fault=00 and data captured.
- Busy handling: pulse `start` again while in REQ → no second transaction, exactly one `done`. Back-to-back `start` in the cycle after `done` → new transaction accepted.
- Reset mid-operation: assert rst_n=0 asynchronously mid-REQ → `mem_req`, `busy` and `load_data` go to 0 before the next edge; after release, a new LW completes normally.
